// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle logic ops, iterative shift-add multiply and restoring divide
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [3:0]         ctrl,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out,
    output logic               zero,
    output logic               err
);
    localparam int W2 = 2 * WIDTH;
    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t            state;
    logic [W2-1:0]     res, acc, mcand, mul_next;
    logic [WIDTH-1:0]  sh, mplier, quo, rem, dvs, quo_next, rem_next;
    logic [WIDTH:0]    r_sh;
    logic [5:0]        cnt;
    logic              res_err, fits;

    // single-cycle result for every opcode that does not iterate
    always_comb begin
        res = '0;
        res_err = 1'b0;
        sh = WIDTH'(b % WIDTH);
        case (ctrl)
            4'b0000: res = W2'(a) + W2'(b);
            4'b0001: res = W2'({a < b, WIDTH'(a - b)});
            4'b0010: res = W2'(a & b);
            4'b0011: res = W2'(a | b);
            4'b0100: res = W2'(a ^ b);
            4'b0101: res = W2'(~a);
            4'b0110: res = W2'(a) << sh;
            4'b0111: res = W2'(a >> sh);
            4'b1000: res = '0;
            4'b1001: begin
                res = {a, {WIDTH{1'b1}}};
                res_err = 1'b1;
            end
            default: res_err = 1'b1;
        endcase
    end

    // next iteration of shift-add multiply and restoring divide
    always_comb begin
        mul_next = acc + (mplier[0] ? mcand : '0);
        r_sh = {rem, quo[WIDTH-1]};
        fits = r_sh >= {1'b0, dvs};
        rem_next = fits ? WIDTH'(r_sh - {1'b0, dvs}) : r_sh[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], fits};
    end

    // control FSM with registered result, flags and handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            out <= '0;
            zero <= 1'b0;
            err <= 1'b0;
            cnt <= '0;
            acc <= '0;
            mcand <= '0;
            mplier <= '0;
            quo <= '0;
            rem <= '0;
            dvs <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cnt <= '0;
                    if (ctrl == 4'b1000) begin
                        state <= MUL;
                        busy <= 1'b1;
                        acc <= '0;
                        mcand <= W2'(a);
                        mplier <= b;
                    end else if (ctrl == 4'b1001 && b != '0) begin
                        state <= DIV;
                        busy <= 1'b1;
                        quo <= a;
                        rem <= '0;
                        dvs <= b;
                    end else begin
                        done <= 1'b1;
                        out <= res;
                        zero <= res == '0;
                        err <= res_err;
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    mcand <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        busy <= 1'b0;
                        done <= 1'b1;
                        out <= mul_next;
                        zero <= mul_next == '0;
                        err <= 1'b0;
                    end
                end
                DIV: begin
                    quo <= quo_next;
                    rem <= rem_next;
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        busy <= 1'b0;
                        done <= 1'b1;
                        out <= {rem_next, quo_next};
                        zero <= {rem_next, quo_next} == '0;
                        err <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH=4
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [3:0] ctrl = '0;
    logic       start = 1'b0;
    logic       busy, done, zero, err;
    logic [7:0] out;
    logic [11:0] obs;
    int checks = 0;
    int failures = 0;

    alu_seq #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .ctrl(ctrl), .start(start),
        .busy(busy), .done(done), .out(out), .zero(zero), .err(err)
    );

    always #5 clk = ~clk;

    assign obs = {busy, done, out, zero, err};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [3:0] oa, input logic [3:0] ob, input logic [3:0] oc);
        a = oa;
        b = ob;
        ctrl = oc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a = 4'd5;
        b = 4'd11;
        ctrl = 4'b0000;
        start = 1'b1;
        tick();
        tick();
        checks++;
        if (obs !== 12'h000) begin
            failures++;
            $display("FAIL reset_state got %h exp %h", obs, 12'h000);
        end
        rst = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if (obs !== 12'h000) begin
            failures++;
            $display("FAIL reset_start_ignored got %h exp %h", obs, 12'h000);
        end
    endtask

    task automatic test_add_sub();
        op(4'd5, 4'd11, 4'b0000);
        checks++;
        if (obs !== {1'b0, 1'b1, 8'h10, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL add got %h exp %h", obs, {1'b0, 1'b1, 8'h10, 1'b0, 1'b0});
        end
        op(4'd5, 4'd11, 4'b0001);
        checks++;
        if (obs !== {1'b0, 1'b1, 8'h1A, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL sub got %h exp %h", obs, {1'b0, 1'b1, 8'h1A, 1'b0, 1'b0});
        end
        tick();
        checks++;
        if (obs !== {1'b0, 1'b0, 8'h1A, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL sub_hold got %h exp %h", obs, {1'b0, 1'b0, 8'h1A, 1'b0, 1'b0});
        end
    endtask

    task automatic test_mul();
        op(4'd5, 4'd11, 4'b1000);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({busy, done} !== 2'b10) begin
                failures++;
                $display("FAIL mul_busy%0d got %b exp %b", i, {busy, done}, 2'b10);
            end
            start = (i == 1);
            a = (i == 1) ? 4'd1 : 4'd0;
            b = (i == 1) ? 4'd1 : 4'd0;
            ctrl = 4'b0000;
            tick();
        end
        start = 1'b0;
        checks++;
        if (obs !== {1'b0, 1'b1, 8'h37, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mul got %h exp %h", obs, {1'b0, 1'b1, 8'h37, 1'b0, 1'b0});
        end
        tick();
        checks++;
        if (obs !== {1'b0, 1'b0, 8'h37, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mul_single_done got %h exp %h", obs, {1'b0, 1'b0, 8'h37, 1'b0, 1'b0});
        end
    endtask

    task automatic test_div();
        op(4'd11, 4'd5, 4'b1001);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({busy, done} !== 2'b10) begin
                failures++;
                $display("FAIL div_busy%0d got %b exp %b", i, {busy, done}, 2'b10);
            end
            tick();
        end
        checks++;
        if (obs !== {1'b0, 1'b1, 8'h12, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL div got %h exp %h", obs, {1'b0, 1'b1, 8'h12, 1'b0, 1'b0});
        end
        op(4'd5, 4'd0, 4'b1001);
        checks++;
        if (obs !== {1'b0, 1'b1, 8'h5F, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL div_zero got %h exp %h", obs, {1'b0, 1'b1, 8'h5F, 1'b0, 1'b1});
        end
    endtask

    task automatic test_shift_unsupported();
        op(4'd5, 4'd3, 4'b0110);
        checks++;
        if (obs !== {1'b0, 1'b1, 8'h28, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL shl got %h exp %h", obs, {1'b0, 1'b1, 8'h28, 1'b0, 1'b0});
        end
        op(4'd5, 4'd3, 4'b0111);
        checks++;
        if (obs !== {1'b0, 1'b1, 8'h00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL shr got %h exp %h", obs, {1'b0, 1'b1, 8'h00, 1'b1, 1'b0});
        end
        op(4'd7, 4'd6, 4'b0100);
        checks++;
        if (obs !== {1'b0, 1'b1, 8'h01, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL xor got %h exp %h", obs, {1'b0, 1'b1, 8'h01, 1'b0, 1'b0});
        end
        op(4'd5, 4'd3, 4'b1111);
        checks++;
        if (obs !== {1'b0, 1'b1, 8'h00, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL unsupported got %h exp %h", obs, {1'b0, 1'b1, 8'h00, 1'b1, 1'b1});
        end
    endtask

    task automatic test_abort();
        int dones = 0;
        op(4'd5, 4'd11, 4'b1000);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (obs !== 12'h000) begin
            failures++;
            $display("FAIL abort_reset got %h exp %h", obs, 12'h000);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            dones += int'(done);
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL abort_no_done got %0d exp %0d", dones, 0);
        end
        op(4'd3, 4'd3, 4'b1000);
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (obs !== {1'b0, 1'b1, 8'h09, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mul_after_abort got %h exp %h", obs, {1'b0, 1'b1, 8'h09, 1'b0, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        a = 4'd5;
        b = 4'd3;
        ctrl = 4'b0000;
        start = 1'b1;
        tick();
        checks++;
        if (obs !== {1'b0, 1'b1, 8'h08, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_add got %h exp %h", obs, {1'b0, 1'b1, 8'h08, 1'b0, 1'b0});
        end
        ctrl = 4'b0010;
        tick();
        start = 1'b0;
        checks++;
        if (obs !== {1'b0, 1'b1, 8'h01, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_and got %h exp %h", obs, {1'b0, 1'b1, 8'h01, 1'b0, 1'b0});
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got %b exp %b", done, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_shift_unsupported();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 4, operand width; SHALL be supported for any value 2..32.
REQ-002 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 A  input  WIDTH  operand A, unsigned; sampled only on an accepted START.
REQ-005 B  input  WIDTH  operand B, unsigned; sampled only on an accepted START.
REQ-006 CTRL  input  4  opcode; sampled only on an accepted START.
REQ-007 START  input  1  request; accepted SHALL mean START=1 while BUSY=0 and RST=0.
REQ-008 BUSY  output  1  high while an iterative operation is in progress.
REQ-009 DONE  output  1  one-cycle pulse marking a new valid OUT.
REQ-010 OUT  output  2*WIDTH  result, held stable until the next DONE.
REQ-011 ZERO  output  1  OUT==0, updated with DONE.
REQ-012 ERR  output  1  divide-by-zero or unsupported opcode, updated with DONE.

Function
REQ-013 Opcodes SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT A, 0110 SHL, 0111 SHR, 1000 MUL, 1001 DIV; 1010-1111 unsupported.
REQ-014 ADD: OUT[WIDTH:0] = A+B (carry at bit WIDTH); upper bits zero.
REQ-015 SUB: OUT[WIDTH-1:0] = (A-B) mod 2^WIDTH, OUT[WIDTH] = borrow (A<B); upper bits zero.
REQ-016 AND/OR/XOR/NOT: bitwise result in OUT[WIDTH-1:0]; upper bits zero.
REQ-017 SHL/SHR: shift A by B mod WIDTH, zero fill; SHL result 2*WIDTH wide (no bits lost); SHR zero-extended.
REQ-018 MUL: unsigned A*B full 2*WIDTH-bit product, computed by iterative shift-add, one operand bit per cycle.
REQ-019 DIV: restoring division A/B, one quotient bit per cycle; OUT[WIDTH-1:0]=quotient, OUT[2*WIDTH-1:WIDTH]=remainder.
REQ-020 FSM states SHALL be IDLE, MUL, DIV; IDLE->MUL on accepted START with 1000; IDLE->DIV on accepted START with 1001 and B!=0; MUL/DIV->IDLE after WIDTH iteration cycles.
REQ-021 Single-cycle ops (all except MUL, DIV with B!=0): START accepted in cycle k -> DONE=1 and OUT valid in cycle k+1; BUSY stays 0.
REQ-022 Iterative ops: START accepted in cycle k -> BUSY=1 in cycles k+1..k+WIDTH, DONE=1 and OUT valid in cycle k+WIDTH+1 with BUSY=0.
REQ-023 A new START SHALL be accepted in the same cycle DONE is high (back-to-back throughput).
REQ-024 START while BUSY=1 SHALL be ignored: no operand capture, no effect on the running operation, no extra DONE.
REQ-025 Operand/opcode changes after acceptance SHALL NOT affect the result in progress.
REQ-026 DIV with B==0: single-cycle, ERR=1, OUT[WIDTH-1:0]=all ones, OUT[2*WIDTH-1:WIDTH]=A.
REQ-027 Unsupported opcode: single-cycle, OUT=0, ZERO=1, ERR=1.
REQ-028 ERR=0 for all other completed operations; ZERO SHALL reflect the OUT presented with the same DONE.
REQ-029 DONE SHALL be exactly one cycle per accepted START; no DONE without an accepted START.

Reset
REQ-030 With RST=1 at a clock edge: state->IDLE, BUSY=0, DONE=0, OUT=0, ZERO=0, ERR=0; START in that cycle SHALL be ignored.
REQ-031 RST asserted mid-MUL/DIV SHALL abort the operation with no DONE; first START accepted after RST deasserts SHALL behave as from power-up.

Verification (WIDTH=4)
REQ-032 A=5, B=11, CTRL=0000, START 1 cycle -> next cycle DONE=1, OUT=8'h10, ZERO=0, ERR=0; CTRL=0001 -> OUT=8'h1A.
REQ-033 A=5, B=11, CTRL=1000 -> BUSY high 4 cycles, DONE in 5th cycle after START, OUT=8'h37; START pulsed during BUSY with A=1, B=1 -> ignored, result still 8'h37, one DONE only.
REQ-034 A=11, B=5, CTRL=1001 -> DONE after 5 cycles, OUT=8'h12; then A=5, B=0, CTRL=1001 -> next cycle DONE, OUT=8'h5F, ERR=1.
REQ-035 A=5, B=3, CTRL=0110 -> OUT=8'h28; CTRL=0111 -> OUT=8'h00, ZERO=1; CTRL=1111 -> OUT=8'h00, ZERO=1, ERR=1.
REQ-036 MUL started, RST pulsed in 2nd BUSY cycle -> no DONE, all outputs 0; then A=3, B=3, CTRL=1000 -> OUT=8'h09 after 5 cycles.
REQ-037 Back-to-back: START held high across DONE cycles for ADD then AND -> one DONE per accepted START, consecutive cycles.
